// File: rtl/dice_referee.sv
// Two-player dice game referee: scores one roll per round, opens a fixed-length
// result window on o_times after each decided round, and declares the winner.
module dice_referee #(
    parameter int ROUNDS      = 5,
    parameter int DISP_CYCLES = 150
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_roll_done,
    input  logic [2:0] i_die1,
    input  logic [2:0] i_die2,
    output logic       o_times,
    output logic       o_is_final,
    output logic       o_is_finish,
    output logic [3:0] o_score1,
    output logic [3:0] o_score2,
    output logic [3:0] o_round,
    output logic [1:0] o_winner,
    output logic       o_bad_roll,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ROLL = 2'd1,
        SHOW      = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam int             CW       = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LOAD = CW'(DISP_CYCLES - 1);
    localparam logic [3:0]     LAST     = 4'(ROUNDS - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_times;
    logic          r_is_final;
    logic          r_is_finish;
    logic [3:0]    r_score1;
    logic [3:0]    r_score2;
    logic [3:0]    r_round;
    logic [1:0]    r_winner;
    logic          r_bad_roll;

    logic w_legal;
    logic w_p1_higher;
    logic w_p2_higher;

    assign w_legal     = (i_die1 >= 3'd1) && (i_die1 <= 3'd6) &&
                         (i_die2 >= 3'd1) && (i_die2 <= 3'd6);
    assign w_p1_higher = i_die1 > i_die2;
    assign w_p2_higher = i_die2 > i_die1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_times     <= 1'b0;
            r_is_final  <= 1'b0;
            r_is_finish <= 1'b0;
            r_score1    <= 4'd0;
            r_score2    <= 4'd0;
            r_round     <= 4'd0;
            r_winner    <= 2'b00;
            r_bad_roll  <= 1'b0;
        end else begin
            r_bad_roll <= 1'b0;
            // start wins over everything, including a same-cycle roll
            if (i_start) begin
                r_state     <= WAIT_ROLL;
                r_cnt       <= '0;
                r_times     <= 1'b0;
                r_is_final  <= (ROUNDS == 1);
                r_is_finish <= 1'b0;
                r_score1    <= 4'd0;
                r_score2    <= 4'd0;
                r_round     <= 4'd0;
                r_winner    <= 2'b00;
            end else begin
                case (r_state)
                    IDLE: ;
                    WAIT_ROLL: begin
                        if (i_roll_done) begin
                            if (!w_legal) begin
                                r_bad_roll <= 1'b1;
                            end else begin
                                if (w_p1_higher && r_score1 != 4'd15) r_score1 <= r_score1 + 4'd1;
                                if (w_p2_higher && r_score2 != 4'd15) r_score2 <= r_score2 + 4'd1;
                                r_times <= 1'b1;
                                r_cnt   <= CNT_LOAD;
                                r_state <= SHOW;
                            end
                        end
                    end
                    SHOW: begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else begin
                            r_times <= 1'b0;
                            if (r_round == LAST) begin
                                r_state     <= DONE;
                                r_is_final  <= 1'b0;
                                r_is_finish <= 1'b1;
                                if (r_score1 > r_score2)      r_winner <= 2'b01;
                                else if (r_score2 > r_score1) r_winner <= 2'b10;
                                else                          r_winner <= 2'b11;
                            end else begin
                                r_state    <= WAIT_ROLL;
                                r_round    <= r_round + 4'd1;
                                r_is_final <= ((r_round + 4'd1) == LAST);
                            end
                        end
                    end
                    DONE: ;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_times     = r_times;
    assign o_is_final  = r_is_final;
    assign o_is_finish = r_is_finish;
    assign o_score1    = r_score1;
    assign o_score2    = r_score2;
    assign o_round     = r_round;
    assign o_winner    = r_winner;
    assign o_bad_roll  = r_bad_roll;
    assign o_state     = r_state;

endmodule

// File: tb/tb_dice_referee.sv
// Bench for dice_referee: directed scenarios plus randomized games checked
// against a round-by-round game model.
module tb_dice_referee;

    localparam int ROUNDS = 3;
    localparam int DISP   = 150;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_SHOW = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       roll_done;
    logic [2:0] die1;
    logic [2:0] die2;
    logic       times;
    logic       is_final;
    logic       is_finish;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [3:0] round_idx;
    logic [1:0] winner;
    logic       bad_roll;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    dice_referee #(.ROUNDS(ROUNDS), .DISP_CYCLES(DISP)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_roll_done(roll_done),
        .i_die1(die1), .i_die2(die2),
        .o_times(times), .o_is_final(is_final), .o_is_finish(is_finish),
        .o_score1(score1), .o_score2(score2), .o_round(round_idx),
        .o_winner(winner), .o_bad_roll(bad_roll), .o_state(state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_roll(input logic [2:0] a, input logic [2:0] b);
        roll_done = 1'b1;
        die1 = a;
        die2 = b;
        step();
        roll_done = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Measures how many sampled cycles o_times stays high, optionally injecting a
    // roll at a given offset; len saturates at 1000 if the window never closes.
    task automatic wait_window(input int inject_at, input logic [2:0] a, input logic [2:0] b,
                               output int len, output logic bad_seen);
        len = 0;
        bad_seen = 1'b0;
        while (times === 1'b1 && len < 1000) begin
            len++;
            if (len == inject_at) begin
                roll_done = 1'b1;
                die1 = a;
                die2 = b;
            end
            step();
            roll_done = 1'b0;
            if (bad_roll === 1'b1) bad_seen = 1'b1;
        end
    endtask

    function automatic logic [1:0] model_winner(input int s1, input int s2);
        if (s1 > s2) return 2'b01;
        if (s2 > s1) return 2'b10;
        return 2'b11;
    endfunction

    task automatic test_reset();
        logic [17:0] outs;
        rst = 1'b1; start = 1'b0; roll_done = 1'b0; die1 = 3'd0; die2 = 3'd0;
        repeat (3) step();
        rst = 1'b0;
        step();
        do_roll(3'd5, 3'd3);
        step();
        outs = {times, is_final, is_finish, bad_roll, score1, score2, round_idx, winner};
        checks++;
        if (outs !== 18'd0) begin errors++; $display("FAIL reset_outputs got %h exp 0", outs); end
        checks++;
        if (state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", state, ST_IDLE); end
    endtask

    task automatic test_scored_round();
        int len;
        logic bad_seen;
        do_start();
        checks++;
        if (state !== ST_WAIT || is_final !== 1'b0) begin
            errors++; $display("FAIL start_state got st=%0d fin=%0b exp st=1 fin=0", state, is_final);
        end
        do_roll(3'd5, 3'd3);
        checks++;
        if (score1 !== 4'd1 || score2 !== 4'd0 || times !== 1'b1) begin
            errors++; $display("FAIL scored_round got s1=%0d s2=%0d t=%0b exp 1 0 1", score1, score2, times);
        end
        wait_window(-1, 3'd0, 3'd0, len, bad_seen);
        checks++;
        if (len != DISP) begin errors++; $display("FAIL scored_window got %0d exp %0d", len, DISP); end
        checks++;
        if (round_idx !== 4'd1 || is_final !== 1'b0 || state !== ST_WAIT) begin
            errors++; $display("FAIL scored_next got rnd=%0d fin=%0b st=%0d exp 1 0 1", round_idx, is_final, state);
        end
    endtask

    task automatic test_tie_ignored();
        int len;
        logic bad_seen;
        do_roll(3'd4, 3'd4);
        checks++;
        if (score1 !== 4'd1 || score2 !== 4'd0 || times !== 1'b1) begin
            errors++; $display("FAIL tie_scores got s1=%0d s2=%0d t=%0b exp 1 0 1", score1, score2, times);
        end
        wait_window(40, 3'd1, 3'd6, len, bad_seen);
        checks++;
        if (len != DISP || bad_seen !== 1'b0) begin
            errors++; $display("FAIL tie_window got len=%0d bad=%0b exp %0d 0", len, bad_seen, DISP);
        end
        checks++;
        if (score1 !== 4'd1 || score2 !== 4'd0 || round_idx !== 4'd2 || is_final !== 1'b1) begin
            errors++; $display("FAIL tie_after got s1=%0d s2=%0d rnd=%0d fin=%0b exp 1 0 2 1",
                               score1, score2, round_idx, is_final);
        end
    endtask

    task automatic test_rejected();
        do_roll(3'd0, 3'd3);
        checks++;
        if (bad_roll !== 1'b1 || state !== ST_WAIT) begin
            errors++; $display("FAIL reject0_pulse got bad=%0b st=%0d exp 1 1", bad_roll, state);
        end
        step();
        checks++;
        if (bad_roll !== 1'b0) begin errors++; $display("FAIL reject0_width got %0b exp 0", bad_roll); end
        do_roll(3'd7, 3'd2);
        checks++;
        if (bad_roll !== 1'b1 || state !== ST_WAIT || times !== 1'b0) begin
            errors++; $display("FAIL reject7_pulse got bad=%0b st=%0d t=%0b exp 1 1 0", bad_roll, state, times);
        end
        step();
        checks++;
        if (bad_roll !== 1'b0 || score1 !== 4'd1 || score2 !== 4'd0) begin
            errors++; $display("FAIL reject7_after got bad=%0b s1=%0d s2=%0d exp 0 1 0", bad_roll, score1, score2);
        end
    endtask

    task automatic test_start_priority();
        start = 1'b1; roll_done = 1'b1; die1 = 3'd0; die2 = 3'd3;
        step();
        start = 1'b0; roll_done = 1'b0;
        checks++;
        if (bad_roll !== 1'b0 || state !== ST_WAIT || score1 !== 4'd0 || score2 !== 4'd0 || round_idx !== 4'd0) begin
            errors++; $display("FAIL start_priority got bad=%0b st=%0d s1=%0d s2=%0d rnd=%0d exp 0 1 0 0 0",
                               bad_roll, state, score1, score2, round_idx);
        end
    endtask

    task automatic test_full_game();
        int len;
        logic bad_seen;
        logic [2:0] rolls_a [3] = '{3'd6, 3'd2, 3'd3};
        logic [2:0] rolls_b [3] = '{3'd1, 3'd5, 3'd1};
        do_start();
        for (int r = 0; r < ROUNDS; r++) begin
            checks++;
            if (round_idx !== 4'(r) || is_final !== (r == ROUNDS - 1)) begin
                errors++; $display("FAIL full_round%0d got rnd=%0d fin=%0b", r, round_idx, is_final);
            end
            do_roll(rolls_a[r], rolls_b[r]);
            wait_window(-1, 3'd0, 3'd0, len, bad_seen);
        end
        checks++;
        if (is_finish !== 1'b1 || is_final !== 1'b0 || times !== 1'b0 || state !== ST_DONE) begin
            errors++; $display("FAIL full_done got fin=%0b isf=%0b t=%0b st=%0d exp 1 0 0 3",
                               is_finish, is_final, times, state);
        end
        checks++;
        if (score1 !== 4'd2 || score2 !== 4'd1 || winner !== 2'b01) begin
            errors++; $display("FAIL full_result got s1=%0d s2=%0d w=%b exp 2 1 01", score1, score2, winner);
        end
        do_roll(3'd1, 3'd6);
        step();
        checks++;
        if (score2 !== 4'd1 || state !== ST_DONE || is_finish !== 1'b1) begin
            errors++; $display("FAIL done_hold got s2=%0d st=%0d fin=%0b exp 1 3 1", score2, state, is_finish);
        end
    endtask

    task automatic test_restart_mid_show();
        do_start();
        do_roll(3'd4, 3'd2);
        repeat (74) step();
        do_start();
        checks++;
        if (times !== 1'b0 || score1 !== 4'd0 || score2 !== 4'd0 || round_idx !== 4'd0 || state !== ST_WAIT) begin
            errors++; $display("FAIL restart got t=%0b s1=%0d s2=%0d rnd=%0d st=%0d exp 0 0 0 0 1",
                               times, score1, score2, round_idx, state);
        end
        repeat (3) step();
        do_roll(3'd3, 3'd6);
        checks++;
        if (score1 !== 4'd0 || score2 !== 4'd1 || times !== 1'b1) begin
            errors++; $display("FAIL restart_roll got s1=%0d s2=%0d t=%0b exp 0 1 1", score1, score2, times);
        end
    endtask

    task automatic test_async_reset();
        logic [17:0] outs;
        repeat (20) step();
        rst = 1'b1;
        #1;
        outs = {times, is_final, is_finish, bad_roll, score1, score2, round_idx, winner};
        checks++;
        if (outs !== 18'd0 || state !== ST_IDLE) begin
            errors++; $display("FAIL async_reset got %h st=%0d exp 0 0", outs, state);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_random_games();
        int len, s1, s2, n_bad, gap;
        logic bad_seen;
        logic [2:0] a, b;
        for (int g = 0; g < 4; g++) begin
            do_start();
            s1 = 0; s2 = 0;
            for (int r = 0; r < ROUNDS; r++) begin
                checks++;
                if (round_idx !== 4'(r) || is_final !== (r == ROUNDS - 1) || is_finish !== 1'b0) begin
                    errors++; $display("FAIL rnd_g%0d_r%0d_flags got rnd=%0d fin=%0b isf=%0b",
                                       g, r, round_idx, is_final, is_finish);
                end
                n_bad = $urandom_range(0, 2);
                for (int k = 0; k < n_bad; k++) begin
                    a = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd7;
                    b = 3'($urandom_range(0, 7));
                    if ($urandom_range(0, 1) == 1) do_roll(b, a);
                    else do_roll(a, b);
                    checks++;
                    if (bad_roll !== 1'b1 || score1 !== 4'(s1) || score2 !== 4'(s2) || times !== 1'b0) begin
                        errors++; $display("FAIL rnd_bad got bad=%0b s1=%0d s2=%0d t=%0b exp 1 %0d %0d 0",
                                           bad_roll, score1, score2, times, s1, s2);
                    end
                end
                gap = $urandom_range(0, 3);
                repeat (gap) step();
                a = 3'($urandom_range(1, 6));
                b = 3'($urandom_range(1, 6));
                do_roll(a, b);
                if (a > b) s1++;
                if (b > a) s2++;
                checks++;
                if (score1 !== 4'(s1) || score2 !== 4'(s2) || times !== 1'b1 || bad_roll !== 1'b0) begin
                    errors++; $display("FAIL rnd_roll got s1=%0d s2=%0d t=%0b bad=%0b exp %0d %0d 1 0",
                                       score1, score2, times, bad_roll, s1, s2);
                end
                wait_window($urandom_range(1, DISP - 1), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                            len, bad_seen);
                checks++;
                if (len != DISP || bad_seen !== 1'b0) begin
                    errors++; $display("FAIL rnd_window got len=%0d bad=%0b exp %0d 0", len, bad_seen, DISP);
                end
            end
            checks++;
            if (is_finish !== 1'b1 || is_final !== 1'b0 || times !== 1'b0 ||
                winner !== model_winner(s1, s2) || score1 !== 4'(s1) || score2 !== 4'(s2)) begin
                errors++; $display("FAIL rnd_g%0d_end got fin=%0b isf=%0b t=%0b w=%b s1=%0d s2=%0d exp 1 0 0 %b %0d %0d",
                                   g, is_finish, is_final, times, winner, score1, score2,
                                   model_winner(s1, s2), s1, s2);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_scored_round();
        test_tie_ignored();
        test_rejected();
        test_start_priority();
        test_full_game();
        test_restart_mid_show();
        test_async_reset();
        test_random_games();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dice_referee.md
# dice_referee

Game-control stage that sits directly upstream of `standby`. It accepts one dice-roll result per round for two players, keeps the round count and both scores, and drives the `times`, `is_final`, `is_finish`, `score1` and `score2` signals that `standby` consumes to choose its LED effects. Each decided round opens a fixed-length result-display window on `times`. The game ends after a programmable number of rounds.

## Interface
- `ROUNDS`, default 5: rounds per game. Legal range is 1..15.
- `DISP_CYCLES`, default 150: length of the `times` result window in clock cycles (1500 ns at 100 MHz). Must be ≥ 1.
- `clk`  in  1  system clock; every register is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; starts or restarts a game.
- `roll_done`  in  1  one-cycle pulse; `die1`/`die2` are valid in this cycle.
- `die1`  in  3  player-1 die face; legal values 1..6.
- `die2`  in  3  player-2 die face; legal values 1..6.
- `times`  out  1  high during a round-result display window.
- `is_final`  out  1  high while the current round is the last round.
- `is_finish`  out  1  high once the game is over.
- `score1`  out  4  player-1 score.
- `score2`  out  4  player-2 score.
- `round`  out  4  current round index, 0-based.
- `winner`  out  2  valid only while `is_finish`=1: 01 = player 1, 10 = player 2, 11 = tie. 00 otherwise.
- `bad_roll`  out  1  one-cycle pulse when a roll is rejected.

## Operation
- The FSM has four states: IDLE, WAIT_ROLL, SHOW, DONE. All outputs are registered.
- **Reset values:** state IDLE; `times`, `is_final`, `is_finish`, `bad_roll` = 0; `score1`, `score2`, `round` = 0; `winner` = 00.
- **`start` (any state):**
  - clear scores and `round`, drop `times`, `is_finish` and `winner`;
  - load `is_final` = (ROUNDS==1);
  - go to WAIT_ROLL.
  - `start` has priority over a `roll_done` in the same cycle; that roll is discarded with no `bad_roll`.
- **IDLE:** `roll_done` is ignored.
- **WAIT_ROLL, on `roll_done`:**
  - If either die is 0 or 7: pulse `bad_roll`; scores and state are unchanged.
  - Otherwise: the higher die scores +1 for its player; equal dice score nothing.
  - Scores saturate at 15 (unreachable when ROUNDS ≤ 15).
  - Set `times`=1, load the display counter, go to SHOW.
- **SHOW:**
  - `times` stays 1 for exactly DISP_CYCLES cycles.
  - `roll_done` is ignored silently: no `bad_roll`.
  - At window end, if `round` == ROUNDS-1: go to DONE with `times`=0, `is_final`=0, `is_finish`=1, and `winner` from the score comparison.
  - Otherwise: `round`+1, `times`=0, `is_final` = (new round == ROUNDS-1), go to WAIT_ROLL.
- **DONE:**
  - Outputs hold.
  - `roll_done` is ignored.
  - Only `start` or `rst` leaves this state.

## Timing
- A `roll_done` sampled at edge k updates the score at edge k, so the score and `times`=1 are visible after edge k.
- `times` falls at edge k+DISP_CYCLES. `round`, `is_final` and `is_finish` change at that same edge.
- The next `roll_done` is accepted from edge k+DISP_CYCLES+1.
- `bad_roll` is high for exactly the one cycle after the rejecting edge.
- `start` takes effect at the sampling edge: WAIT_ROLL is entered and outputs are cleared after that edge.
- `rst` asserted mid-SHOW clears all outputs immediately, without waiting for a clock edge.
- `is_final` and `is_finish` are never high together.
- `times` is 0 whenever `is_finish` = 1.

## Test plan
- **Reset and idle.** Assert `rst`; then with `start`=0, pulse `roll_done` with die1=5, die2=3.
  - Required: all outputs stay at their reset values.
- **Scored round.** `start`, then `roll_done` with die1=5, die2=3 (DISP_CYCLES=150).
  - Required: `score1`=1, `score2`=0, `times` high for exactly 150 cycles, then `round`=1.
- **Tie and ignored roll.** A round with die1=4, die2=4, plus a second `roll_done` issued during SHOW.
  - Required: scores unchanged, window length still 150 cycles, no `bad_roll`.
- **Rejected rolls.** In WAIT_ROLL, `roll_done` with die1=0 and die2=3, then with die1=7 and die2=2.
  - Required: two one-cycle `bad_roll` pulses, state stays WAIT_ROLL, scores unchanged.
- **Full game.** ROUNDS=3, rolls (6,1), (2,5), (3,1).
  - Required: `is_final`=1 only during round 2.
  - After the last window: `is_finish`=1, `is_final`=0, `score1`=2, `score2`=1, `winner`=01.
- **Restart mid-SHOW.** Pulse `start` halfway through a SHOW window.
  - Required: `times`=0, scores and `round` = 0, state WAIT_ROLL on the next cycle.
  - A following (3,6) roll gives `score2`=1.
